// File: rtl/axis_ram_pkg.sv
// Constants and helpers shared by the AXI RAM writer and reader stages.
package axis_ram_pkg;

    localparam int unsigned BURST_LEN    = 16;
    localparam logic [3:0]  ARLEN        = 4'd15;
    localparam logic [1:0]  ARBURST_INCR = 2'b01;
    localparam logic [3:0]  ARCACHE_WB   = 4'b1111;

    typedef enum logic {StIdle, StReq} ar_state_e;

    // Ceiling log2; 0 for values <= 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v != 0) begin
                r++;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: registered-read RAM plus an output
// register, with a bypass so a write into an empty FIFO is visible the next cycle.
module sync_fifo_fwft
    import axis_ram_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 512
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = clogb2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      mem_cnt_q, mem_cnt_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] dout_q;
    logic             pop, load, from_mem, bypass, mem_wr;

    always_comb begin
        pop       = rd_en & out_valid_q;
        load      = ~out_valid_q | pop;
        from_mem  = load & (mem_cnt_q != '0);
        // With the RAM empty, incoming data goes straight to the output register.
        bypass    = load & (mem_cnt_q == '0) & wr_en;
        mem_wr    = wr_en & ~bypass;
        mem_cnt_d = mem_cnt_q + (AW + 1)'(mem_wr) - (AW + 1)'(from_mem);
    end

    always_ff @(posedge aclk) begin
        if (mem_wr) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge aclk) begin
        if (from_mem) begin
            dout_q <= mem[rd_ptr_q];
        end else if (bypass) begin
            dout_q <= din;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            if (mem_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (from_mem) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (load) begin
                out_valid_q <= from_mem | bypass;
            end
        end
    end

    assign full  = (mem_cnt_q + (AW + 1)'(out_valid_q)) == (AW + 1)'(DEPTH);
    assign empty = ~out_valid_q;
    assign dout  = dout_q;

endmodule

// File: rtl/axis_ram_reader.sv
// AXI3 read master that plays a circular RAM buffer out as AXI4-Stream, using
// FIFO credits so every requested beat already has a slot and rready stays high.
module axis_ram_reader
    import axis_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 20,
    parameter int unsigned AXI_ID_WIDTH     = 6,
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXIS_TDATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH       = 512
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   cfg_data,
    output logic [ADDR_WIDTH-1:0]       sts_data,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [3:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic [3:0]                  m_axi_arcache,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready
);

    localparam int unsigned CW            = clogb2(FIFO_DEPTH) + 1;
    localparam int unsigned SIZE          = clogb2(AXI_DATA_WIDTH / 8);
    localparam logic [CW-1:0] BURST_CREDITS = CW'(BURST_LEN);

    ar_state_e                 state_q, state_d;
    logic [CW-1:0]             credits_q, credits_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]   arid_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [ADDR_WIDTH-1:0]     sts_q;
    logic [3:0]                beat_q;
    logic                      ar_fire, axis_fire, load_addr;
    logic                      fifo_wr, fifo_full, fifo_empty;
    logic [AXI_DATA_WIDTH-1:0] fifo_dout;

    assign m_axi_arvalid = (state_q == StReq);
    assign ar_fire       = m_axi_arvalid & m_axi_arready;
    assign axis_fire     = m_axis_tvalid & m_axis_tready;
    assign m_axi_rready  = aresetn;
    assign fifo_wr       = m_axi_rvalid & m_axi_rready;

    always_comb begin
        credits_d = credits_q;
        if (ar_fire) begin
            credits_d = credits_d - BURST_CREDITS;
        end
        if (axis_fire) begin
            credits_d = credits_d + CW'(1);
        end
        addr_d  = ar_fire ? addr_q + ADDR_WIDTH'(BURST_LEN) : addr_q;
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (credits_d >= BURST_CREDITS) state_d = StReq;
            StReq:   if (ar_fire && (credits_d < BURST_CREDITS)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // cfg_data is sampled whenever a fresh request is about to be presented.
        load_addr = (state_d == StReq) && ((state_q == StIdle) || ar_fire);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            credits_q <= CW'(FIFO_DEPTH);
            addr_q    <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            sts_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            addr_q    <= addr_d;
            if (ar_fire) begin
                arid_q <= arid_q + AXI_ID_WIDTH'(1);
            end
            if (load_addr) begin
                araddr_q <= cfg_data + (AXI_ADDR_WIDTH'(addr_d) << SIZE);
            end
            if (axis_fire) begin
                sts_q <= sts_q + ADDR_WIDTH'(1);
            end
            if (fifo_wr) begin
                beat_q <= beat_q + 4'd1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (fifo_wr),
        .din     (m_axi_rdata),
        .full    (fifo_full),
        .rd_en   (m_axis_tready),
        .dout    (fifo_dout),
        .empty   (fifo_empty)
    );

    assign sts_data      = sts_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = ARLEN;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = ARBURST_INCR;
    assign m_axi_arcache = ARCACHE_WB;
    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_dout[AXIS_TDATA_WIDTH-1:0];

    // A write into a full FIFO means the credit accounting is broken.
    a_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(fifo_wr && fifo_full));
    a_rlast_pos: assert property (@(posedge aclk) disable iff (!aresetn)
        fifo_wr |-> (m_axi_rlast == (beat_q == 4'd15)));

endmodule
